// File: rtl/gcd_fsm_ctrl.sv
// rtl/gcd_fsm_ctrl.sv - control unit sequencing a subtractive-GCD datapath
//
// Purpose: Moore FSM that loads the A/B operand registers, compares them,
//          subtracts the smaller from the larger until they are equal, and
//          reports completion to the host. An iteration watchdog ends runs
//          that cannot converge (a zero operand) and flags err_timeout.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      run request, sampled only in IDLE
//   a_neq_b      in   1      datapath status: A != B
//   a_lt_b       in   1      datapath status: A < B
//   sel_init     out  1      1: A/B muxes take external operands, 0: subtractors
//   ld_a         out  1      A register load enable
//   ld_b         out  1      B register load enable
//   busy         out  1      high in LOAD, CMP, SUB_A, SUB_B
//   done         out  1      one-cycle completion pulse, A holds the GCD
//   err_timeout  out  1      last run ended by the watchdog
//   iter_cnt     out  CNT_W  subtractions in the current or last run

module gcd_fsm_ctrl #(
    parameter int MAX_ITER = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a_neq_b,
    input  logic             a_lt_b,
    output logic             sel_init,
    output logic             ld_a,
    output logic             ld_b,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [CNT_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMP,
        S_SUB_A,
        S_SUB_B,
        S_DONE
    } state_t;

    typedef struct packed {
        logic sel_init;
        logic ld_a;
        logic ld_b;
        logic busy;
        logic done;
    } outs_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    state_t state;
    outs_t  outs;

    // Output pattern of each state. The output register is always loaded with
    // the pattern of the state being entered, so outs always equals
    // out_of(state) and the outputs are glitch-free registers.
    function automatic outs_t out_of(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            S_LOAD:  begin o.sel_init = 1'b1; o.ld_a = 1'b1; o.ld_b = 1'b1; o.busy = 1'b1; end
            S_CMP:   o.busy = 1'b1;
            S_SUB_A: begin o.ld_a = 1'b1; o.busy = 1'b1; end
            S_SUB_B: begin o.ld_b = 1'b1; o.busy = 1'b1; end
            S_DONE:  o.done = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            outs        <= '0;
            iter_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        outs        <= out_of(S_LOAD);
                        // Clear run status on entry so LOAD already shows a fresh run.
                        iter_cnt    <= '0;
                        err_timeout <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                        outs  <= out_of(S_IDLE);
                    end
                end
                S_LOAD: begin
                    state <= S_CMP;
                    outs  <= out_of(S_CMP);
                end
                S_CMP: begin
                    // Equality wins over the watchdog: a run that converges on
                    // its last allowed subtraction is still a clean result.
                    if (!a_neq_b) begin
                        state <= S_DONE;
                        outs  <= out_of(S_DONE);
                    end else if (iter_cnt == MAX_CNT) begin
                        state       <= S_DONE;
                        outs        <= out_of(S_DONE);
                        err_timeout <= 1'b1;
                    end else if (a_lt_b) begin
                        state <= S_SUB_B;
                        outs  <= out_of(S_SUB_B);
                    end else begin
                        state <= S_SUB_A;
                        outs  <= out_of(S_SUB_A);
                    end
                end
                S_SUB_A, S_SUB_B: begin
                    state <= S_CMP;
                    outs  <= out_of(S_CMP);
                    if (iter_cnt != MAX_CNT) begin
                        iter_cnt <= iter_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    outs  <= out_of(S_IDLE);
                end
                default: begin
                    state <= S_IDLE;
                    outs  <= '0;
                end
            endcase
        end
    end

    assign sel_init = outs.sel_init;
    assign ld_a     = outs.ld_a;
    assign ld_b     = outs.ld_b;
    assign busy     = outs.busy;
    assign done     = outs.done;

endmodule

// File: tb/tb_gcd_fsm_ctrl.sv
// tb/tb_gcd_fsm_ctrl.sv - scoreboard bench for gcd_fsm_ctrl with a behavioural 4-bit datapath

module tb_gcd_fsm_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       a_neq_b;
    logic       a_lt_b;
    logic       sel_init;
    logic       ld_a;
    logic       ld_b;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic [3:0] iter_cnt;

    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [3:0] ra;
    logic [3:0] rb;

    int cyc;
    int n_done;
    int vectors;
    int miscompares;

    typedef struct {
        int res;
        int cnt;
        int err;
        int cyc;
    } exp_t;

    exp_t sb[$];

    gcd_fsm_ctrl #(.MAX_ITER(15), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a_neq_b     (a_neq_b),
        .a_lt_b      (a_lt_b),
        .sel_init    (sel_init),
        .ld_a        (ld_a),
        .ld_b        (ld_b),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .iter_cnt    (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: A/B registers with init and subtract muxes.
    always @(posedge clk) begin
        if (ld_a) ra <= sel_init ? a_in : ra - rb;
        if (ld_b) rb <= sel_init ? b_in : rb - ra;
    end
    assign a_neq_b = (ra != rb);
    assign a_lt_b  = (ra < rb);

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: GCD by Euclid; the subtractive algorithm performs
    // (sum of Euclid quotients - 1) subtractions. A zero operand never
    // converges, so the watchdog fires after 15 subtractions.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int x, y, t, s;
        e.err = 0;
        e.cyc = 0;
        if (a == 0 && b == 0) begin
            e.res = 0; e.cnt = 0;
        end else if (a == 0 || b == 0) begin
            e.res = a; e.cnt = 15; e.err = 1;
        end else begin
            x = a; y = b; s = 0;
            while (y != 0) begin
                s += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            e.res = x;
            e.cnt = s - 1;
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    initial begin
        exp_t e;
        logic prev_done;
        n_done    = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ld_a && ld_b && !sel_init) chk("ld_both_outside_load", 1, 0);
                if (done && busy)              chk("done_with_busy", 1, 0);
                if (done && prev_done)         chk("done_not_pulse", 1, 0);
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("gcd_result", int'(ra), e.res);
                        chk("iter_cnt", int'(iter_cnt), e.cnt);
                        chk("err_timeout", int'(err_timeout), e.err);
                        chk("done_cycle", cyc, e.cyc);
                    end
                    n_done = n_done + 1;
                end
                prev_done = done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    task automatic wait_done(input int n0);
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            if (n_done > n0) return;
        end
        chk("done_wait_expired", 0, 1);
    endtask

    task automatic run_one(input int a, input int b);
        exp_t e;
        int   n0;
        @(posedge clk); #1;
        a_in  = 4'(a);
        b_in  = 4'(b);
        start = 1'b1;
        e     = model(a, b);
        e.cyc = cyc + 3 + 2 * e.cnt;
        sb.push_back(e);
        n0    = n_done;
        @(posedge clk); #1;
        start = 1'b0;
        chk("load_busy", int'(busy), 1);
        chk("load_sel_init", int'(sel_init), 1);
        @(posedge clk); #1;
        chk("cmp_err_clear", int'(err_timeout), 0);
        chk("cmp_cnt_clear", int'(iter_cnt), 0);
        wait_done(n0);
    endtask

    initial begin
        exp_t e;
        int   n0;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        a_in        = '0;
        b_in        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({sel_init, ld_a, ld_b, busy, done, err_timeout, iter_cnt}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed runs
        run_one(9, 9);
        run_one(12, 8);
        run_one(15, 1);
        run_one(0, 5);
        run_one(6, 4);

        // start held high through a run: one done, relaunch only from IDLE
        @(posedge clk); #1;
        a_in  = 4'd12;
        b_in  = 4'd8;
        start = 1'b1;
        e     = model(12, 8);
        e.cyc = cyc + 3 + 2 * e.cnt;
        sb.push_back(e);
        n0 = n_done;
        wait_done(n0);
        #1;
        chk("held_start_idle_gap", int'(busy), 0);
        e     = model(12, 8);
        e.cyc = cyc + 3 + 2 * e.cnt;
        sb.push_back(e);
        n0 = n_done;
        @(posedge clk); #1;
        chk("held_start_reload", int'(busy & sel_init), 1);
        start = 1'b0;
        wait_done(n0);

        // Reset in the middle of SUB_A
        @(posedge clk); #1;
        a_in  = 4'd12;
        b_in  = 4'd8;
        start = 1'b1;
        n0    = n_done;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("sub_a_ld_a", int'({ld_a, ld_b, sel_init, busy}), 4'b1001);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", int'({sel_init, ld_a, ld_b, busy, done, err_timeout, iter_cnt}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        chk("no_done_after_reset", n_done, n0);
        run_one(12, 8);

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_one(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
